// File: rtl/fractal_iter_engine_if.sv
// Pixel handshake between the load distributor, one iteration engine and the VGA arbiter.
// The slave side is the engine; the master side is whoever feeds pixels and drains colours.
interface fractal_iter_engine_if #(
  parameter int DATA_W  = 36,
  parameter int ITER_W  = 12,
  parameter int COLOR_W = 4,
  parameter int VGA_X_W = 10,
  parameter int VGA_Y_W = 9
);
  logic                         iDataVal;
  logic signed [DATA_W-1:0]     iCoordX;
  logic signed [DATA_W-1:0]     iCoordY;
  logic [VGA_X_W-1:0]           iVGAX;
  logic [VGA_Y_W-1:0]           iVGAY;
  logic                         iMode;
  logic signed [DATA_W-1:0]     iJuliaRe;
  logic signed [DATA_W-1:0]     iJuliaIm;
  logic                         iColorMode;
  logic                         iAbort;
  logic                         iValueStored;
  logic                         oProcReady;
  logic [COLOR_W-1:0]           oColor;
  logic [ITER_W-1:0]            oIter;
  logic [VGA_X_W+VGA_Y_W-1:0]   oVGACoord;
  logic                         oVGAVal;

  modport slave (
    input  iDataVal, iCoordX, iCoordY, iVGAX, iVGAY, iMode, iJuliaRe, iJuliaIm,
           iColorMode, iAbort, iValueStored,
    output oProcReady, oColor, oIter, oVGACoord, oVGAVal
  );

  modport master (
    output iDataVal, iCoordX, iCoordY, iVGAX, iVGAY, iMode, iJuliaRe, iJuliaIm,
           iColorMode, iAbort, iValueStored,
    input  oProcReady, oColor, oIter, oVGACoord, oVGAVal
  );
endinterface

// File: rtl/fractal_iter_engine.sv
// Escape-time iteration engine for Mandelbrot/Julia pixels: one z <- z^2 + c step per clock,
// then a held-valid colour result that waits for the VGA arbiter to store it.
module fractal_iter_engine #(
  parameter int DATA_W       = 36,
  parameter int FRAC_W       = 32,
  parameter int MAX_ITER     = 512,
  parameter int ITER_W       = 12,
  parameter int ESC_R2       = 4,
  parameter int COLOR_W      = 4,
  parameter int IN_SET_COLOR = 0,
  parameter int VGA_X_W      = 10,
  parameter int VGA_Y_W      = 9
) (
  input logic clk,
  input logic reset,
  fractal_iter_engine_if.slave bus
);

  localparam int PW = 2 * DATA_W;
  localparam logic [PW:0] ESC_THRESH = (PW+1)'(ESC_R2) << (2 * FRAC_W);

  typedef enum logic [1:0] {INIT, IDLE, ITER, OUT} state_t;
  state_t state, stateNext;

  logic signed [DATA_W-1:0] zr, zi, cr, ci;
  logic [ITER_W-1:0] iter;
  logic colorMode;
  logic procReady, vgaVal;
  logic [COLOR_W-1:0] color;
  logic [ITER_W-1:0] iterOut;
  logic [VGA_X_W+VGA_Y_W-1:0] vgaCoord;

  logic signed [PW-1:0] zrEx, ziEx, zrSq, ziSq, zrZi, sqDiff;
  logic [PW:0] mag;
  logic atLimit, escaped;
  logic signed [DATA_W-1:0] zrNext, ziNext;

  // Squares are exact at double width; the magnitude gets one extra bit so the compare cannot wrap.
  assign zrEx    = {{DATA_W{zr[DATA_W-1]}}, zr};
  assign ziEx    = {{DATA_W{zi[DATA_W-1]}}, zi};
  assign zrSq    = zrEx * zrEx;
  assign ziSq    = ziEx * ziEx;
  assign zrZi    = zrEx * ziEx;
  assign sqDiff  = zrSq - ziSq;
  assign mag     = {1'b0, zrSq} + {1'b0, ziSq};
  assign atLimit = (iter == ITER_W'(MAX_ITER));
  assign escaped = (mag > ESC_THRESH);
  assign zrNext  = DATA_W'(sqDiff >>> FRAC_W) + cr;
  assign ziNext  = DATA_W'((zrZi <<< 1) >>> FRAC_W) + ci;

  function automatic logic [COLOR_W-1:0] log2Map(input logic [ITER_W-1:0] v);
    logic [COLOR_W-1:0] r;
    r = '0;
    for (int i = 1; i < ITER_W; i++)
      if (v[i]) r = (i > (2**COLOR_W) - 1) ? '1 : COLOR_W'(i);
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= stateNext;
  end

  // Abort takes priority over every other transition, including acceptance in IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      INIT: stateNext = IDLE;
      IDLE: if (bus.iDataVal && !bus.iAbort) stateNext = ITER;
      ITER: begin
        if (bus.iAbort)                stateNext = IDLE;
        else if (atLimit || escaped)   stateNext = OUT;
      end
      OUT: begin
        if (bus.iAbort)                       stateNext = IDLE;
        else if (vgaVal && bus.iValueStored)  stateNext = IDLE;
      end
      default: stateNext = INIT;
    endcase
  end

  // The first OUT cycle only raises valid, so a store strobe seen before valid is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zr        <= '0;
      zi        <= '0;
      cr        <= '0;
      ci        <= '0;
      iter      <= '0;
      colorMode <= 1'b0;
      procReady <= 1'b0;
      vgaVal    <= 1'b0;
      color     <= '0;
      iterOut   <= '0;
      vgaCoord  <= '0;
    end else begin
      case (state)
        INIT: procReady <= 1'b1;
        IDLE: begin
          if (bus.iDataVal && !bus.iAbort) begin
            vgaCoord  <= {bus.iVGAX, bus.iVGAY};
            colorMode <= bus.iColorMode;
            iter      <= '0;
            procReady <= 1'b0;
            if (bus.iMode) begin
              zr <= bus.iCoordX;
              zi <= bus.iCoordY;
              cr <= bus.iJuliaRe;
              ci <= bus.iJuliaIm;
            end else begin
              zr <= '0;
              zi <= '0;
              cr <= bus.iCoordX;
              ci <= bus.iCoordY;
            end
          end
        end
        ITER: begin
          if (bus.iAbort) begin
            procReady <= 1'b1;
          end else if (atLimit) begin
            color   <= COLOR_W'(IN_SET_COLOR);
            iterOut <= iter;
          end else if (escaped) begin
            color   <= colorMode ? iter[COLOR_W-1:0] : log2Map(iter);
            iterOut <= iter;
          end else begin
            zr   <= zrNext;
            zi   <= ziNext;
            iter <= iter + ITER_W'(1);
          end
        end
        OUT: begin
          if (bus.iAbort) begin
            vgaVal    <= 1'b0;
            procReady <= 1'b1;
          end else if (!vgaVal) begin
            vgaVal <= 1'b1;
          end else if (bus.iValueStored) begin
            vgaVal    <= 1'b0;
            procReady <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oProcReady = procReady;
  assign bus.oVGAVal    = vgaVal;
  assign bus.oColor     = color;
  assign bus.oIter      = iterOut;
  assign bus.oVGACoord  = vgaCoord;

endmodule

// File: tb/tb_fractal_iter_engine.sv
// Directed bench for fractal_iter_engine: reset, escape latencies, colour maps, backpressure, abort.
module tb_fractal_iter_engine;
  localparam int DATA_W = 36, FRAC_W = 32, MAX_ITER = 512, ITER_W = 12;
  localparam int COLOR_W = 4, VGA_X_W = 10, VGA_Y_W = 9;
  localparam int CW = VGA_X_W + VGA_Y_W;

  localparam logic signed [DATA_W-1:0] ZERO   = '0;
  localparam logic signed [DATA_W-1:0] HALF   = 36'sh0_8000_0000;
  localparam logic signed [DATA_W-1:0] ONEP5  = 36'sh1_8000_0000;
  localparam logic signed [DATA_W-1:0] TWO    = 36'sh2_0000_0000;
  localparam logic signed [DATA_W-1:0] MTWO   = -36'sh2_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fractal_iter_engine_if #(.DATA_W(DATA_W), .ITER_W(ITER_W), .COLOR_W(COLOR_W),
                           .VGA_X_W(VGA_X_W), .VGA_Y_W(VGA_Y_W)) bus ();

  fractal_iter_engine #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W),
                        .ESC_R2(4), .COLOR_W(COLOR_W), .IN_SET_COLOR(0),
                        .VGA_X_W(VGA_X_W), .VGA_Y_W(VGA_Y_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  // Offer one pixel on a falling edge; returns just after the accepting rising edge.
  task automatic applyStimulus(input logic mode, input logic signed [DATA_W-1:0] cx,
                               input logic signed [DATA_W-1:0] cy,
                               input logic signed [DATA_W-1:0] jr,
                               input logic signed [DATA_W-1:0] ji, input logic cmode,
                               input logic [VGA_X_W-1:0] vx, input logic [VGA_Y_W-1:0] vy);
    @(negedge clk);
    bus.iMode = mode; bus.iCoordX = cx; bus.iCoordY = cy;
    bus.iJuliaRe = jr; bus.iJuliaIm = ji; bus.iColorMode = cmode;
    bus.iVGAX = vx; bus.iVGAY = vy; bus.iDataVal = 1'b1;
    @(posedge clk);
    #1;
    bus.iDataVal = 1'b0;
  endtask

  // Clocks from the accept edge until oVGAVal is seen; -1 if the budget runs out.
  task automatic waitValid(output int lat);
    lat = -1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk);
      #1;
      if (bus.oVGAVal === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic applyConsume(output logic v, output logic r);
    @(negedge clk);
    bus.iValueStored = 1'b1;
    @(posedge clk);
    #1;
    v = bus.oVGAVal;
    r = bus.oProcReady;
    bus.iValueStored = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (bus.oProcReady !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%b want=0", bus.oProcReady); end
    total++; if (bus.oVGAVal !== 1'b0) begin bad++; $display("[TB] FAIL rst_val got=%b want=0", bus.oVGAVal); end
    total++; if (bus.oColor !== '0) begin bad++; $display("[TB] FAIL rst_color got=%0d want=0", bus.oColor); end
    total++; if (bus.oIter !== '0) begin bad++; $display("[TB] FAIL rst_iter got=%0d want=0", bus.oIter); end
    total++; if (bus.oVGACoord !== '0) begin bad++; $display("[TB] FAIL rst_coord got=%h want=0", bus.oVGACoord); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.oProcReady !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready got=%b want=1", bus.oProcReady); end
  endtask

  task automatic test_in_set_zero();
    int lat; logic v, r;
    logic [CW-1:0] expCoord;
    expCoord = {10'd3, 9'd7};
    applyStimulus(1'b0, ZERO, ZERO, ZERO, ZERO, 1'b0, 10'd3, 9'd7);
    total++; if (bus.oProcReady !== 1'b0) begin bad++; $display("[TB] FAIL inset_busy got=%b want=0", bus.oProcReady); end
    waitValid(lat);
    total++; if (lat !== MAX_ITER + 2) begin bad++; $display("[TB] FAIL inset_latency got=%0d want=%0d", lat, MAX_ITER + 2); end
    total++; if (bus.oIter !== 12'd512) begin bad++; $display("[TB] FAIL inset_iter got=%0d want=512", bus.oIter); end
    total++; if (bus.oColor !== 4'd0) begin bad++; $display("[TB] FAIL inset_color got=%0d want=0", bus.oColor); end
    total++; if (bus.oVGACoord !== expCoord) begin bad++; $display("[TB] FAIL inset_coord got=%h want=%h", bus.oVGACoord, expCoord); end
    applyConsume(v, r);
    total++; if (v !== 1'b0 || r !== 1'b1) begin bad++; $display("[TB] FAIL inset_consume got val=%b rdy=%b want val=0 rdy=1", v, r); end
  endtask

  task automatic test_escape_two();
    int lat; logic v, r;
    applyStimulus(1'b0, TWO, ZERO, ZERO, ZERO, 1'b0, 10'd1, 9'd2);
    waitValid(lat);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL esc2_latency got=%0d want=4", lat); end
    total++; if (bus.oIter !== 12'd2) begin bad++; $display("[TB] FAIL esc2_iter got=%0d want=2", bus.oIter); end
    total++; if (bus.oColor !== 4'd1) begin bad++; $display("[TB] FAIL esc2_color got=%0d want=1", bus.oColor); end
    applyConsume(v, r);
  endtask

  task automatic test_minus_two();
    int lat; logic v, r;
    applyStimulus(1'b0, MTWO, ZERO, ZERO, ZERO, 1'b1, 10'd4, 9'd5);
    waitValid(lat);
    total++; if (lat !== MAX_ITER + 2) begin bad++; $display("[TB] FAIL m2_latency got=%0d want=%0d", lat, MAX_ITER + 2); end
    total++; if (bus.oIter !== 12'd512) begin bad++; $display("[TB] FAIL m2_iter got=%0d want=512", bus.oIter); end
    total++; if (bus.oColor !== 4'd0) begin bad++; $display("[TB] FAIL m2_color got=%0d want=0", bus.oColor); end
    applyConsume(v, r);
  endtask

  task automatic test_julia();
    int lat; logic v, r;
    applyStimulus(1'b1, ONEP5, ZERO, ZERO, ZERO, 1'b1, 10'd9, 9'd9);
    waitValid(lat);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL julia_lin_latency got=%0d want=3", lat); end
    total++; if (bus.oIter !== 12'd1) begin bad++; $display("[TB] FAIL julia_lin_iter got=%0d want=1", bus.oIter); end
    total++; if (bus.oColor !== 4'd1) begin bad++; $display("[TB] FAIL julia_lin_color got=%0d want=1", bus.oColor); end
    applyConsume(v, r);
    applyStimulus(1'b1, ONEP5, ZERO, ZERO, ZERO, 1'b0, 10'd9, 9'd9);
    waitValid(lat);
    total++; if (bus.oColor !== 4'd0) begin bad++; $display("[TB] FAIL julia_log_color got=%0d want=0", bus.oColor); end
    applyConsume(v, r);
  endtask

  task automatic test_complex_c();
    int lat; logic v, r;
    applyStimulus(1'b0, HALF, HALF, ZERO, ZERO, 1'b1, 10'd0, 9'd0);
    waitValid(lat);
    total++; if (lat !== 7) begin bad++; $display("[TB] FAIL cplx_latency got=%0d want=7", lat); end
    total++; if (bus.oIter !== 12'd5) begin bad++; $display("[TB] FAIL cplx_iter got=%0d want=5", bus.oIter); end
    total++; if (bus.oColor !== 4'd5) begin bad++; $display("[TB] FAIL cplx_lin_color got=%0d want=5", bus.oColor); end
    applyConsume(v, r);
    applyStimulus(1'b0, HALF, HALF, ZERO, ZERO, 1'b0, 10'd0, 9'd0);
    waitValid(lat);
    total++; if (bus.oColor !== 4'd2) begin bad++; $display("[TB] FAIL cplx_log_color got=%0d want=2", bus.oColor); end
    applyConsume(v, r);
  endtask

  task automatic test_backpressure();
    int lat; logic v, r;
    logic [CW-1:0] expCoord;
    expCoord = {10'h155, 9'h0AA};
    applyStimulus(1'b0, TWO, ZERO, ZERO, ZERO, 1'b0, 10'h155, 9'h0AA);
    waitValid(lat);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=4", lat); end
    for (int c = 0; c < 10; c++) begin
      total++;
      if (bus.oVGAVal !== 1'b1 || bus.oProcReady !== 1'b0 || bus.oColor !== 4'd1 ||
          bus.oIter !== 12'd2 || bus.oVGACoord !== expCoord) begin
        bad++;
        $display("[TB] FAIL bp_hold cyc=%0d got val=%b rdy=%b col=%0d it=%0d xy=%h want val=1 rdy=0 col=1 it=2 xy=%h",
                 c, bus.oVGAVal, bus.oProcReady, bus.oColor, bus.oIter, bus.oVGACoord, expCoord);
      end
      @(posedge clk);
      #1;
    end
    applyConsume(v, r);
    total++; if (v !== 1'b0 || r !== 1'b1) begin bad++; $display("[TB] FAIL bp_consume got val=%b rdy=%b want val=0 rdy=1", v, r); end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    bus.iMode = 1'b0; bus.iCoordX = TWO; bus.iCoordY = ZERO;
    bus.iDataVal = 1'b1; bus.iAbort = 1'b1;
    @(posedge clk);
    #1;
    bus.iDataVal = 1'b0; bus.iAbort = 1'b0;
    total++; if (bus.oProcReady !== 1'b1) begin bad++; $display("[TB] FAIL abort_idle_ready got=%b want=1", bus.oProcReady); end
    repeat (8) @(posedge clk);
    #1;
    total++; if (bus.oVGAVal !== 1'b0) begin bad++; $display("[TB] FAIL abort_idle_val got=%b want=0", bus.oVGAVal); end
  endtask

  task automatic test_abort_iter();
    logic sawVal;
    applyStimulus(1'b0, ZERO, ZERO, ZERO, ZERO, 1'b0, 10'd2, 9'd2);
    repeat (100) @(posedge clk);
    @(negedge clk);
    bus.iAbort = 1'b1;
    @(posedge clk);
    #1;
    bus.iAbort = 1'b0;
    total++; if (bus.oProcReady !== 1'b1) begin bad++; $display("[TB] FAIL abort_iter_ready got=%b want=1", bus.oProcReady); end
    sawVal = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.oVGAVal === 1'b1) sawVal = 1'b1;
    end
    total++; if (sawVal !== 1'b0) begin bad++; $display("[TB] FAIL abort_iter_noval got=%b want=0", sawVal); end
  endtask

  task automatic test_reset_mid_iter();
    applyStimulus(1'b0, ZERO, ZERO, ZERO, ZERO, 1'b0, 10'd8, 9'd8);
    repeat (50) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if (bus.oProcReady !== 1'b0 || bus.oVGAVal !== 1'b0 || bus.oColor !== '0 ||
        bus.oIter !== '0 || bus.oVGACoord !== '0) begin
      bad++;
      $display("[TB] FAIL midrst_outputs got rdy=%b val=%b col=%0d it=%0d xy=%h want all 0",
               bus.oProcReady, bus.oVGAVal, bus.oColor, bus.oIter, bus.oVGACoord);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.oProcReady !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready got=%b want=1", bus.oProcReady); end
  endtask

  initial begin
    bus.iDataVal = 1'b0; bus.iCoordX = '0; bus.iCoordY = '0; bus.iVGAX = '0; bus.iVGAY = '0;
    bus.iMode = 1'b0; bus.iJuliaRe = '0; bus.iJuliaIm = '0; bus.iColorMode = 1'b0;
    bus.iAbort = 1'b0; bus.iValueStored = 1'b0;
    test_reset();
    test_in_set_zero();
    test_escape_two();
    test_minus_two();
    test_julia();
    test_complex_c();
    test_backpressure();
    test_abort_idle();
    test_abort_iter();
    test_reset_mid_iter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fractal_iter_engine.md
Name: fractal_iter_engine

Overview:
Parametrised escape-time iteration engine. It is the next generation of the lab4 per-pixel Mandelbrot processor and is generalised in fixed-point width, iteration limit, escape radius and colour depth. It adds a runtime Mandelbrot/Julia mode, a selectable colour map, a per-pixel abort, and a held-valid output handshake. It sits between the load distributor (coordinate in) and the VGA buffer arbiter (colour out); several instances run in parallel.

Parameters:
DATA_W, 36, signed fixed-point width of coordinates and z.
FRAC_W, 32, fractional bits (default format 4.32).
MAX_ITER, 512, iteration limit; must satisfy MAX_ITER < 2^ITER_W.
ITER_W, 12, iteration counter width.
ESC_R2, 4, integer escape threshold on |z|^2 (strict greater-than).
COLOR_W, 4, colour output width.
IN_SET_COLOR, 0, colour emitted for non-escaping points.
VGA_X_W, 10, screen X width.
VGA_Y_W, 9, screen Y width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
iDataVal  in  1  new pixel offered; accepted only when oProcReady=1
iCoordX  in  DATA_W  pixel real coordinate (signed)
iCoordY  in  DATA_W  pixel imaginary coordinate (signed)
iVGAX  in  VGA_X_W  screen x
iVGAY  in  VGA_Y_W  screen y
iMode  in  1  0=Mandelbrot, 1=Julia; sampled at accept
iJuliaRe  in  DATA_W  Julia constant, real part; sampled at accept
iJuliaIm  in  DATA_W  Julia constant, imaginary part; sampled at accept
iColorMode  in  1  0=log2 map, 1=linear (low COLOR_W bits); sampled at accept
iAbort  in  1  synchronous cancel of the current pixel
iValueStored  in  1  arbiter has consumed the result
oProcReady  out  1  idle, able to accept
oColor  out  COLOR_W  pixel colour
oIter  out  ITER_W  final iteration count
oVGACoord  out  VGA_X_W+VGA_Y_W  {x,y}
oVGAVal  out  1  result valid, held until consumed

Behaviour:
- States: INIT, IDLE, ITER, OUT.
- Reset (reset=0, asynchronous): state=INIT; all outputs 0. First clock after release: INIT->IDLE, oProcReady<=1.
- IDLE, accept when iDataVal=1 and iAbort=0:
  - Latch the VGA coordinate, iColorMode and iMode.
  - Mandelbrot: z0=0, c={iCoordX,iCoordY}. Julia: z0={iCoordX,iCoordY}, c={iJuliaRe,iJuliaIm}.
  - iter<=0, oProcReady<=0, state->ITER.
  - If iDataVal and iAbort are high together in IDLE, abort wins and nothing is accepted.
- ITER: one iteration per clock on the current z.
  - Squares zr*zr, zi*zi and product zr*zi are formed at full 2*DATA_W width.
  - mag = zr^2+zi^2 is formed at 2*DATA_W+1 bits and compared against ESC_R2<<(2*FRAC_W). The compare never wraps.
  - Check order:
    - iter==MAX_ITER: colour=IN_SET_COLOR, ->OUT.
    - else mag > threshold: colour=map(iter), ->OUT.
    - else zr<=(zr^2-zi^2)>>>FRAC_W + cr; zi<=(2*zr*zi)>>>FRAC_W + ci; both truncated to DATA_W bits (wrap permitted); iter++.
  - oIter<=iter on the exit transition.
- Colour maps:
  - log2: floor(log2(iter)), with iter 0 -> 0, saturated at 2^COLOR_W-1.
  - linear: iter[COLOR_W-1:0].
- Latency: an escape at count k raises oVGAVal k+2 clocks after the accept edge. An in-set pixel raises it MAX_ITER+2 clocks after accept.
- OUT:
  - oVGAVal=1. oColor, oIter and oVGACoord are stable while oVGAVal=1.
  - When iValueStored=1: next clock oVGAVal=0, oProcReady=1, ->IDLE.
  - iValueStored while oVGAVal=0 is ignored.
- iAbort in ITER or OUT: next clock ->IDLE, oVGAVal=0, oProcReady=1, no result emitted.
- A new pixel can be accepted no earlier than the cycle after the return to IDLE.

Test Plan:
- Mandelbrot, c=0, log2 map -> oVGAVal 514 clocks after accept; oColor=0, oIter=512.
- Mandelbrot, c=2.0 (0x2_0000_0000) -> |z1|^2=4 does not escape (strict >); escapes at iter=2; oColor=1, oIter=2, oVGAVal 4 clocks after accept.
- Mandelbrot, c=-2.0 -> z stays at 2, |z|^2=4 forever, never escapes; oIter=512, oColor=IN_SET_COLOR.
- Julia, coord=1.5, const=0, linear map -> escapes at iter=1; oColor=1. With the log2 map -> oColor=0.
- Backpressure: hold iValueStored=0 for 10 clocks after oVGAVal rises -> outputs stable and oProcReady=0 throughout; 1-cycle iValueStored -> oVGAVal=0 and oProcReady=1 next clock.
- iAbort at iteration 100 -> no oVGAVal, oProcReady=1 next clock. Also assert reset mid-ITER -> all outputs 0 immediately; oProcReady=1 one clock after release.
